edge_collision_detector: RTL
============================

Name: edge_collision_detector

Overview:
- Upstream stage of the collision resolver.
- For one point body per request, walks the closed terrain polygon held in vertex BRAM and tests the motion segment P→P+D against each edge (v[i], v[(i+1) mod N]).
- On the first hitting edge in index order, it presents v1/v2, position, velocity and dx/dy to the resolver with a one-cycle valid pulse, then waits for the resolver to finish.
- If no edge is hit, it reports a miss directly.

Parameters:
- POSITION_SIZE, 8, signed width of positions, vertices, dx/dy
- VELOCITY_SIZE, 8, signed width of velocities
- DT, 1, timestep multiplier: dx = vel_x*DT, truncated to POSITION_SIZE
- NUM_VERTICES, 4, vertex count N (≥3)
- MEM_LATENCY, 2, BRAM read latency in cycles (≥1)

Ports:
- clk_in  input  1  clock
- rst_in  input  1  synchronous active-high reset
- start_in  input  1  request pulse; sampled only in IDLE
- pos_x, pos_y  input  POSITION_SIZE signed  point position; latched on start
- vel_x, vel_y  input  VELOCITY_SIZE signed  point velocity; latched on start
- vertex_addr_out  output  $clog2(NUM_VERTICES)  BRAM read address
- vertex_x_in, vertex_y_in  input  POSITION_SIZE signed  BRAM data, valid MEM_LATENCY cycles after address
- resolve_done_in  input  1  resolver output_valid
- coll_valid_out  output  1  one-cycle pulse to resolver input_valid
- v1_out, v2_out  output  POSITION_SIZE signed [1:0]  edge endpoints, [0]=x, [1]=y
- pos_x_out, pos_y_out, vel_x_out, vel_y_out, dx_out, dy_out  output  as inputs  latched values to resolver
- busy_out  output  1  high in every state except IDLE
- done_out  output  1  one-cycle completion pulse
- hit_out  output  1  valid with done_out; 1 means an edge was hit and resolved

Behaviour:
- Reset: state IDLE; all outputs 0, including the vertex address.
- Reset mid-operation aborts the walk. No coll_valid_out or done_out is emitted for the aborted request.
- States: IDLE, READ, CROSS, CHECK, WAIT_RESOLVE, DONE.
- IDLE:
  - On start_in, latch the inputs.
  - Compute dx/dy.
  - Set edge index k=0 and drive address 0.
  - Go to READ (reading the first vertex).
- READ:
  - Lasts MEM_LATENCY+1 cycles. The address is driven on the first cycle and the data is sampled on the last cycle.
  - First-vertex read: store the vertex as A, then perform the READ for vertex (k+1) mod N.
  - Other reads: store the vertex as B, then go to CROSS.
  - The last edge re-reads vertex 0; do not reuse a cached copy.
- CROSS (1 cycle): register the four cross products at full width (2*POSITION_SIZE+3, no overflow):
  - o1 = cross(B−A, P−A)
  - o2 = cross(B−A, P+D−A)
  - o3 = cross(D, A−P)
  - o4 = cross(D, B−P)
- CHECK (1 cycle): hit iff all of the following hold:
  - D ≠ (0,0)
  - o1 ≠ 0
  - sign(o2) ≠ sign(o1), where o2 = 0 counts as a hit
  - o3 and o4 are not both strictly positive and not both strictly negative
- Boundary cases of the hit rule:
  - A start point exactly on an edge (o1=0) never hits, to avoid re-colliding after resolution.
  - Collinear motion never hits.
- CHECK transitions:
  - On hit: drive v1_out=A, v2_out=B and the latched pos/vel/dx/dy; pulse coll_valid_out on the following cycle; go to WAIT_RESOLVE.
  - On miss with k<N−1: A←B, k←k+1, go to READ.
  - On miss with k=N−1: go to DONE with hit=0.
- WAIT_RESOLVE: hold all resolver-facing outputs stable until resolve_done_in=1, then go to DONE with hit=1. A resolve_done_in seen in any other state is ignored.
- DONE (1 cycle): done_out=1, hit_out set; next state IDLE.
- start_in while busy is ignored; no queuing.
- Miss latency: start sampled at cycle 0, done_out at cycle (MEM_LATENCY+1) + N·(MEM_LATENCY+3) + 1. With defaults this is 24.
- Hit on edge k: coll_valid_out at cycle (MEM_LATENCY+1) + (k+1)·(MEM_LATENCY+3) + 1.

Test Plan:
- Square (0,0),(10,0),(10,10),(0,10); defaults; P=(5,2), vel=(0,−4) → edge 0 hit; coll_valid_out at cycle 9 with v1=(0,0), v2=(10,0), dx=0, dy=−4; resolve_done_in at cycle 20 → done_out/hit_out=1 at cycle 21.
- Same square; P=(5,5), vel=(1,1) → no hit; done_out at cycle 24 with hit_out=0; coll_valid_out never asserted.
- P=(5,2), vel=(0,−2) (endpoint exactly on edge 0) → hit on edge 0; P=(5,0), vel=(0,−3) (starting on edge) → no hit on edge 0.
- vel=(0,0) → no hit, done at cycle 24; start_in pulsed again at cycle 5 → ignored, exactly one done_out.
- Assert rst_in during WAIT_RESOLVE → next cycle IDLE, all outputs 0; a subsequent resolve_done_in produces no done_out.
- Corner hit: P=(12,12), vel=(−4,−4) → hits edge 1 ((10,0)-(10,10)) first by index order; v1=(10,0), v2=(10,10).

Source files
------------

// File: rtl/edge_collision_detector.sv
`default_nettype none
// ============================================================================
// Module      : edge_collision_detector
// Description : Upstream stage of the collision resolver. For one point body
//               per request it walks the closed terrain polygon held in vertex
//               BRAM and tests the motion segment P -> P+D against every edge
//               (v[i], v[(i+1) mod N]) in index order. The first hitting edge
//               is presented to the resolver with a one-cycle valid pulse and
//               the block then waits for the resolver to finish. If no edge is
//               hit, a miss is reported directly.
//
// Ports       : clk_in            clock
//               rst_in            synchronous active-high reset
//               start_in          request pulse, sampled only while idle
//               pos_x/pos_y       point position (latched on start)
//               vel_x/vel_y       point velocity (latched on start)
//               vertex_addr_out   vertex BRAM read address
//               vertex_x_in/_y_in vertex BRAM read data (MEM_LATENCY cycles)
//               resolve_done_in   resolver output_valid
//               coll_valid_out    one-cycle pulse to resolver input_valid
//               v1_out/v2_out     hit edge endpoints, [0]=x, [1]=y
//               pos_*/vel_*/dx/dy latched request values to the resolver
//               busy_out          high whenever not idle
//               done_out          one-cycle completion pulse
//               hit_out           valid with done_out, 1 = edge hit+resolved
//
// Revision    : 1.0 - initial release
// ============================================================================
module edge_collision_detector #(
    parameter int POSITION_SIZE = 8,
    parameter int VELOCITY_SIZE = 8,
    parameter int DT            = 1,
    parameter int NUM_VERTICES  = 4,
    parameter int MEM_LATENCY   = 2
) (
    input  logic                                   clk_in,
    input  logic                                   rst_in,
    input  logic                                   start_in,
    input  logic signed [POSITION_SIZE-1:0]        pos_x,
    input  logic signed [POSITION_SIZE-1:0]        pos_y,
    input  logic signed [VELOCITY_SIZE-1:0]        vel_x,
    input  logic signed [VELOCITY_SIZE-1:0]        vel_y,
    output logic [$clog2(NUM_VERTICES)-1:0]        vertex_addr_out,
    input  logic signed [POSITION_SIZE-1:0]        vertex_x_in,
    input  logic signed [POSITION_SIZE-1:0]        vertex_y_in,
    input  logic                                   resolve_done_in,
    output logic                                   coll_valid_out,
    output logic signed [POSITION_SIZE-1:0]        v1_out [1:0],
    output logic signed [POSITION_SIZE-1:0]        v2_out [1:0],
    output logic signed [POSITION_SIZE-1:0]        pos_x_out,
    output logic signed [POSITION_SIZE-1:0]        pos_y_out,
    output logic signed [VELOCITY_SIZE-1:0]        vel_x_out,
    output logic signed [VELOCITY_SIZE-1:0]        vel_y_out,
    output logic signed [POSITION_SIZE-1:0]        dx_out,
    output logic signed [POSITION_SIZE-1:0]        dy_out,
    output logic                                   busy_out,
    output logic                                   done_out,
    output logic                                   hit_out
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_AW  = $clog2(NUM_VERTICES);
    // Cross products of (P+1)-bit by (P+2)-bit differences, then subtracted:
    // 2*P+3 bits holds every result without overflow.
    localparam int c_XW  = 2 * POSITION_SIZE + 3;
    localparam int c_LCW = $clog2(MEM_LATENCY + 1);

    localparam logic [c_AW-1:0]        c_LAST_IDX = c_AW'(NUM_VERTICES - 1);
    localparam logic [c_LCW-1:0]       c_LAT_LAST = c_LCW'(MEM_LATENCY);
    localparam logic signed [31:0]     c_DT       = 32'(DT);

    // ------------------------------------------------------------------------
    // State machine encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_READ         = 3'd1,
        S_CROSS        = 3'd2,
        S_CHECK        = 3'd3,
        S_WAIT_RESOLVE = 3'd4,
        S_DONE         = 3'd5
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [c_LCW-1:0]               r_lat_cnt;   // cycle within a READ
    logic                           r_first;     // current READ fetches vertex A
    logic [c_AW-1:0]                r_k;         // current edge index
    logic [c_AW-1:0]                r_addr;
    logic signed [POSITION_SIZE-1:0] r_px, r_py;
    logic signed [VELOCITY_SIZE-1:0] r_vx, r_vy;
    logic signed [POSITION_SIZE-1:0] r_dx, r_dy;
    logic signed [POSITION_SIZE-1:0] r_ax, r_ay, r_bx, r_by;
    logic signed [c_XW-1:0]          r_o1, r_o2, r_o3, r_o4;
    logic signed [POSITION_SIZE-1:0] r_v1x, r_v1y, r_v2x, r_v2y;
    logic                           r_coll_valid;
    logic                           r_hit;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic                           w_read_last;
    logic [c_AW-1:0]                w_k_inc;
    logic signed [POSITION_SIZE-1:0] w_dx_new, w_dy_new;

    logic signed [c_XW-1:0] w_ax, w_ay, w_bx, w_by;
    logic signed [c_XW-1:0] w_px, w_py, w_dx, w_dy;
    logic signed [c_XW-1:0] w_ex, w_ey;
    logic signed [c_XW-1:0] w_o1, w_o2, w_o3, w_o4;

    logic w_d_nonzero;
    logic w_o1_nonzero;
    logic w_o2_crosses;
    logic w_o3_pos, w_o3_neg, w_o4_pos, w_o4_neg;
    logic w_hit;

    // Next vertex index around the closed polygon.
    function automatic logic [c_AW-1:0] f_next_idx(input logic [c_AW-1:0] idx);
        logic [c_AW-1:0] res;
        if (idx == c_LAST_IDX) begin
            res = '0;
        end else begin
            res = idx + 1'b1;
        end
        return res;
    endfunction

    assign w_read_last = (r_lat_cnt == c_LAT_LAST);
    assign w_k_inc     = r_k + 1'b1;

    // Displacement for one timestep, truncated to the position width.
    assign w_dx_new = POSITION_SIZE'(32'(vel_x) * c_DT);
    assign w_dy_new = POSITION_SIZE'(32'(vel_y) * c_DT);

    // Sign-extend every operand to the full cross-product width so that all
    // intermediate sums and products are exact.
    assign w_ax = c_XW'(r_ax);
    assign w_ay = c_XW'(r_ay);
    assign w_bx = c_XW'(r_bx);
    assign w_by = c_XW'(r_by);
    assign w_px = c_XW'(r_px);
    assign w_py = c_XW'(r_py);
    assign w_dx = c_XW'(r_dx);
    assign w_dy = c_XW'(r_dy);

    assign w_ex = w_bx - w_ax;
    assign w_ey = w_by - w_ay;

    // cross(u, v) = u.x * v.y - u.y * v.x
    assign w_o1 = w_ex * (w_py - w_ay)        - w_ey * (w_px - w_ax);
    assign w_o2 = w_ex * (w_py + w_dy - w_ay) - w_ey * (w_px + w_dx - w_ax);
    assign w_o3 = w_dx * (w_ay - w_py)        - w_dy * (w_ax - w_px);
    assign w_o4 = w_dx * (w_by - w_py)        - w_dy * (w_bx - w_px);

    // Hit rule. A start point on the edge line (o1 = 0) never hits, which
    // also excludes collinear motion; an endpoint landing exactly on the
    // edge line (o2 = 0) does count.
    assign w_d_nonzero  = (r_dx != '0) || (r_dy != '0);
    assign w_o1_nonzero = (r_o1 != '0);
    assign w_o2_crosses = (r_o2 == '0) || (r_o2[c_XW-1] != r_o1[c_XW-1]);
    assign w_o3_pos     = !r_o3[c_XW-1] && (r_o3 != '0);
    assign w_o3_neg     =  r_o3[c_XW-1];
    assign w_o4_pos     = !r_o4[c_XW-1] && (r_o4 != '0);
    assign w_o4_neg     =  r_o4[c_XW-1];
    assign w_hit        = w_d_nonzero && w_o1_nonzero && w_o2_crosses
                          && !(w_o3_pos && w_o4_pos)
                          && !(w_o3_neg && w_o4_neg);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and status outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        busy_out     = 1'b1;
        done_out     = 1'b0;
        hit_out      = 1'b0;

        case (r_state)
            S_IDLE: begin
                busy_out = 1'b0;
                if (start_in) begin
                    w_state_next = S_READ;
                end
            end
            S_READ: begin
                // After the vertex-A fetch another READ follows for vertex B.
                if (w_read_last && !r_first) begin
                    w_state_next = S_CROSS;
                end
            end
            S_CROSS: begin
                w_state_next = S_CHECK;
            end
            S_CHECK: begin
                if (w_hit) begin
                    w_state_next = S_WAIT_RESOLVE;
                end else if (r_k == c_LAST_IDX) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_READ;
                end
            end
            S_WAIT_RESOLVE: begin
                if (resolve_done_in) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                done_out     = 1'b1;
                hit_out      = r_hit;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_lat_cnt    <= '0;
            r_first      <= 1'b0;
            r_k          <= '0;
            r_addr       <= '0;
            r_px         <= '0;
            r_py         <= '0;
            r_vx         <= '0;
            r_vy         <= '0;
            r_dx         <= '0;
            r_dy         <= '0;
            r_ax         <= '0;
            r_ay         <= '0;
            r_bx         <= '0;
            r_by         <= '0;
            r_o1         <= '0;
            r_o2         <= '0;
            r_o3         <= '0;
            r_o4         <= '0;
            r_v1x        <= '0;
            r_v1y        <= '0;
            r_v2x        <= '0;
            r_v2y        <= '0;
            r_coll_valid <= 1'b0;
            r_hit        <= 1'b0;
        end else begin
            r_coll_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start_in) begin
                        r_px      <= pos_x;
                        r_py      <= pos_y;
                        r_vx      <= vel_x;
                        r_vy      <= vel_y;
                        r_dx      <= w_dx_new;
                        r_dy      <= w_dy_new;
                        r_k       <= '0;
                        r_addr    <= '0;
                        r_lat_cnt <= '0;
                        r_first   <= 1'b1;
                        r_hit     <= 1'b0;
                    end
                end
                S_READ: begin
                    if (w_read_last) begin
                        r_lat_cnt <= '0;
                        if (r_first) begin
                            r_ax    <= vertex_x_in;
                            r_ay    <= vertex_y_in;
                            r_first <= 1'b0;
                            r_addr  <= f_next_idx(r_k);
                        end else begin
                            r_bx <= vertex_x_in;
                            r_by <= vertex_y_in;
                        end
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 1'b1;
                    end
                end
                S_CROSS: begin
                    r_o1 <= w_o1;
                    r_o2 <= w_o2;
                    r_o3 <= w_o3;
                    r_o4 <= w_o4;
                end
                S_CHECK: begin
                    if (w_hit) begin
                        r_v1x        <= r_ax;
                        r_v1y        <= r_ay;
                        r_v2x        <= r_bx;
                        r_v2y        <= r_by;
                        r_coll_valid <= 1'b1;
                        r_hit        <= 1'b1;
                    end else if (r_k != c_LAST_IDX) begin
                        // Slide the window: this edge's end starts the next.
                        // The closing edge fetches vertex 0 from BRAM again.
                        r_ax   <= r_bx;
                        r_ay   <= r_by;
                        r_k    <= w_k_inc;
                        r_addr <= f_next_idx(w_k_inc);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------------
    assign vertex_addr_out = r_addr;
    assign coll_valid_out  = r_coll_valid;
    assign v1_out[0]       = r_v1x;
    assign v1_out[1]       = r_v1y;
    assign v2_out[0]       = r_v2x;
    assign v2_out[1]       = r_v2y;
    assign pos_x_out       = r_px;
    assign pos_y_out       = r_py;
    assign vel_x_out       = r_vx;
    assign vel_y_out       = r_vy;
    assign dx_out          = r_dx;
    assign dy_out          = r_dy;

endmodule
`default_nettype wire
